// File: rtl/baud_tick_gen.sv
// baud_tick_gen: fractional-divisor baud tick generator for the UART TX/RX pair.
// Produces oversample, mid-bit and bit-boundary ticks plus a bit-rate square wave.
// The divisor is Q(INT_W.FRAC_W). Each oversample period lasts div_int cycles, plus
// one extra cycle whenever the fractional accumulator carries. The divisor can be
// reprogrammed while running and takes effect on a bit boundary.
module baud_tick_gen #(
  parameter int CLK_FRQ = 100000000,
  parameter int BAUD    = 115200,
  parameter int OSR     = 16,
  parameter int INT_W   = 16,
  parameter int FRAC_W  = 4,
  parameter int DIV_DEF = int'((64'(CLK_FRQ) << FRAC_W) / (64'(BAUD) * 64'(OSR)))
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     resync,
  input  logic                     cfg_load,
  input  logic [INT_W-1:0]         cfg_div_int,
  input  logic [FRAC_W-1:0]        cfg_div_frac,
  output logic                     cfg_ack,
  output logic                     cfg_err,
  output logic                     os_tick,
  output logic                     mid_tick,
  output logic                     bit_tick,
  output logic                     baud_clk,
  output logic [$clog2(OSR)-1:0]   os_phase
);

  localparam int PH_W  = $clog2(OSR);
  localparam int CNT_W = INT_W + 1;   // one spare bit so div_int + carry never wraps
  localparam logic [INT_W+FRAC_W-1:0] DEF_Q      = (INT_W+FRAC_W)'(DIV_DEF);
  localparam logic [INT_W-1:0]        DEF_INT    = DEF_Q[INT_W+FRAC_W-1:FRAC_W];
  localparam logic [FRAC_W-1:0]       DEF_FRAC   = DEF_Q[FRAC_W-1:0];
  localparam logic [PH_W-1:0]         PH_LAST    = PH_W'(OSR - 1);
  localparam logic [PH_W-1:0]         PH_PRE_MID = PH_W'(OSR / 2 - 1);

  // Active divisor and the pending (not yet applied) divisor
  logic [INT_W-1:0]  div_int_reg;
  logic [FRAC_W-1:0] div_frac_reg;
  logic              pend_valid_reg;
  logic [INT_W-1:0]  pend_int_reg;
  logic [FRAC_W-1:0] pend_frac_reg;

  // Period generation state; period_reg holds the length of the period in progress
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  period_reg;
  logic [FRAC_W-1:0] acc_reg;
  logic [PH_W-1:0]   os_phase_reg;

  // Registered outputs
  logic cfg_ack_reg;
  logic cfg_err_reg;
  logic os_tick_reg;
  logic mid_tick_reg;
  logic bit_tick_reg;
  logic baud_clk_reg;

  logic              load_ok;
  logic              wrap;
  logic              bit_wrap;
  logic [FRAC_W:0]   acc_sum;

  // A divisor with integer part below 2 cannot form a period and is refused
  assign load_ok  = cfg_load && (cfg_div_int >= INT_W'(2));
  assign wrap     = (cnt_reg == period_reg - CNT_W'(1));
  assign bit_wrap = wrap && (os_phase_reg == PH_LAST);
  assign acc_sum  = {1'b0, acc_reg} + {1'b0, div_frac_reg};

  // Counter, phase, configuration and tick registers; rst > !en > resync > counting
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      div_int_reg    <= DEF_INT;
      div_frac_reg   <= DEF_FRAC;
      pend_valid_reg <= 1'b0;
      pend_int_reg   <= '0;
      pend_frac_reg  <= '0;
      cnt_reg        <= '0;
      period_reg     <= {1'b0, DEF_INT};
      acc_reg        <= '0;
      os_phase_reg   <= '0;
      cfg_ack_reg    <= 1'b0;
      cfg_err_reg    <= 1'b0;
      os_tick_reg    <= 1'b0;
      mid_tick_reg   <= 1'b0;
      bit_tick_reg   <= 1'b0;
      baud_clk_reg   <= 1'b0;
    end else begin
      cfg_err_reg  <= cfg_load && !load_ok;
      cfg_ack_reg  <= 1'b0;
      os_tick_reg  <= 1'b0;
      mid_tick_reg <= 1'b0;
      bit_tick_reg <= 1'b0;
      if (!en) begin
        // Idle: clear the phase; a new or pending divisor is applied immediately
        cnt_reg      <= '0;
        acc_reg      <= '0;
        os_phase_reg <= '0;
        baud_clk_reg <= 1'b0;
        if (load_ok) begin
          div_int_reg    <= cfg_div_int;
          div_frac_reg   <= cfg_div_frac;
          period_reg     <= {1'b0, cfg_div_int};
          pend_valid_reg <= 1'b0;
          cfg_ack_reg    <= 1'b1;
        end else if (pend_valid_reg) begin
          div_int_reg    <= pend_int_reg;
          div_frac_reg   <= pend_frac_reg;
          period_reg     <= {1'b0, pend_int_reg};
          pend_valid_reg <= 1'b0;
          cfg_ack_reg    <= 1'b1;
        end else begin
          period_reg <= {1'b0, div_int_reg};
        end
      end else if (resync) begin
        // Phase restart: no tick this cycle, any pending divisor starts now
        cnt_reg      <= '0;
        acc_reg      <= '0;
        os_phase_reg <= '0;
        baud_clk_reg <= 1'b0;
        if (pend_valid_reg) begin
          div_int_reg  <= pend_int_reg;
          div_frac_reg <= pend_frac_reg;
          period_reg   <= {1'b0, pend_int_reg};
          cfg_ack_reg  <= 1'b1;
        end else begin
          period_reg <= {1'b0, div_int_reg};
        end
        if (load_ok) begin
          pend_int_reg   <= cfg_div_int;
          pend_frac_reg  <= cfg_div_frac;
          pend_valid_reg <= 1'b1;
        end else begin
          pend_valid_reg <= 1'b0;
        end
      end else begin
        if (wrap) begin
          cnt_reg      <= '0;
          os_phase_reg <= os_phase_reg + PH_W'(1);
          os_tick_reg  <= 1'b1;
          mid_tick_reg <= (os_phase_reg == PH_PRE_MID);
          bit_tick_reg <= (os_phase_reg == PH_LAST);
          if (os_phase_reg == PH_PRE_MID) baud_clk_reg <= 1'b1;
          if (os_phase_reg == PH_LAST)    baud_clk_reg <= 1'b0;
          if (bit_wrap && pend_valid_reg) begin
            // New divisor governs the next bit from a clean fractional phase
            div_int_reg  <= pend_int_reg;
            div_frac_reg <= pend_frac_reg;
            acc_reg      <= '0;
            period_reg   <= {1'b0, pend_int_reg};
            cfg_ack_reg  <= 1'b1;
          end else begin
            acc_reg    <= acc_sum[FRAC_W-1:0];
            period_reg <= {1'b0, div_int_reg} + CNT_W'(acc_sum[FRAC_W]);
          end
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
        // A load coinciding with the applying boundary waits for the next one
        if (load_ok) begin
          pend_int_reg   <= cfg_div_int;
          pend_frac_reg  <= cfg_div_frac;
          pend_valid_reg <= 1'b1;
        end else if (bit_wrap && pend_valid_reg) begin
          pend_valid_reg <= 1'b0;
        end
      end
    end
  end

  assign cfg_ack  = cfg_ack_reg;
  assign cfg_err  = cfg_err_reg;
  assign os_tick  = os_tick_reg;
  assign mid_tick = mid_tick_reg;
  assign bit_tick = bit_tick_reg;
  assign baud_clk = baud_clk_reg;
  assign os_phase = os_phase_reg;

endmodule

// File: doc/baud_tick_gen.md
Name: baud_tick_gen

Overview:
- Parametrised successor to the fixed baud clock divider, feeding the UART TX/RX pair of the 8-bit CPU's serial port.
- Generates, from `sys_clk`:
  - an oversampling tick (`os_tick`);
  - a mid-bit sample tick (`mid_tick`);
  - a bit-boundary tick (`bit_tick`);
  - a one-bit-period square wave (`baud_clk`).
- The divisor has 4 fractional bits, so baud error stays below 0.1 %.
- The divisor can be reprogrammed at run time, and the phase can be resynchronised so RX can align to a start-bit edge.

Parameters:
- CLK_FRQ, 100000000: `sys_clk` frequency in Hz.
- BAUD, 115200: baud rate loaded at reset.
- OSR, 16: oversampling ratio. Power of two, 4..64.
- INT_W, 16: width of the integer part of the divisor.
- FRAC_W, 4: width of the fractional part of the divisor.
- DIV_DEF, (CLK_FRQ*2^FRAC_W)/(BAUD*OSR): reset divisor in Q(INT_W.FRAC_W). With the defaults this is 868, i.e. 54.25 cycles.

Ports:
- `sys_clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  generator enable.
- `resync`  in  1  single-cycle phase restart request.
- `cfg_load`  in  1  single-cycle strobe that captures a new divisor.
- `cfg_div_int`  in  INT_W  integer part of the new divisor.
- `cfg_div_frac`  in  FRAC_W  fractional part of the new divisor.
- `cfg_ack`  out  1  one-cycle pulse when a new divisor takes effect.
- `cfg_err`  out  1  one-cycle pulse when a `cfg_load` is rejected.
- `os_tick`  out  1  one-cycle pulse per oversample period.
- `mid_tick`  out  1  one-cycle pulse at the mid-bit sample point.
- `bit_tick`  out  1  one-cycle pulse at each bit boundary.
- `baud_clk`  out  1  square wave with a period of one bit time.
- `os_phase`  out  $clog2(OSR)  current oversample index within the bit.

Behaviour:
- **Reset:** `rst` is synchronous and active-high.
  - Active divisor ← DIV_DEF. No pending configuration.
  - `cnt` = 0, `acc` = 0, `os_phase` = 0.
  - All outputs are 0.
- **Output timing:** all outputs are registered.
- **Priority, highest first:** `rst`, then `en` = 0, then `resync`, then normal counting.
- **`en` = 0:**
  - `cnt`, `acc`, `os_phase` and `baud_clk` are cleared to 0.
  - All ticks are 0.
  - A `cfg_load` (or an already pending configuration) is applied on the next edge, and `cfg_ack` pulses in the cycle after.
- **Period generation (`en` = 1):**
  - `cnt` increments each cycle.
  - When `cnt` = period−1: `cnt` ← 0 and `os_tick` is high in the following cycle.
  - `acc` is an FRAC_W-bit accumulator. At every `os_tick`, `acc` ← `acc` + `div_frac`.
  - Next period = `div_int` + carry out of that add.
  - The first period after reset, enable or resync is `div_int` cycles (`acc` = 0).
  - Consecutive `os_tick` pulses are exactly one period apart.
- **Phase counter:**
  - `os_phase` increments modulo OSR on each `os_tick`.
  - `bit_tick` is asserted with the `os_tick` on which `os_phase` wraps OSR−1 → 0.
  - `mid_tick` is asserted with the `os_tick` on which `os_phase` becomes OSR/2.
- **`baud_clk`:** set to 1 on `mid_tick`, cleared to 0 on `bit_tick`. Its period is OSR oversample periods.
- **`resync` with `en` = 1:**
  - `cnt`, `acc`, `os_phase` ← 0 and `baud_clk` ← 0. No tick is issued in that cycle.
  - The first `mid_tick` follows OSR/2 periods later; the first `bit_tick` follows OSR periods later.
  - A pending configuration is applied at the resync edge, with `cfg_ack` in the next cycle.
  - A `resync` on the same edge as a wrap suppresses that tick.
- **Configuration:**
  - `cfg_load` with `cfg_div_int` < 2 is rejected: `cfg_err` pulses next cycle and the pending state is unchanged.
  - Otherwise, with `en` = 1, the values are held as pending.
  - A second valid `cfg_load` before application overwrites the pending values (last write wins) and still yields one `cfg_ack`.
  - The pending divisor is applied at the edge that generates a `bit_tick`, so it governs the next bit onward. `cfg_ack` is coincident with that `bit_tick`.
  - A `cfg_load` on the same edge as the applying `bit_tick` is held pending for the following boundary.
- **Width rules:**
  - The period counter is INT_W+1 bits, so `div_int` + 1 never overflows.
  - The FRAC_W carry out is the only source of period stretching.
- **Reset mid-operation:** everything returns to reset values on the next edge; pending configuration is discarded.

Test Plan:
- **Default rate:** reset, then hold `en`=1 with defaults.
  - `os_tick` spacing repeats 54,54,54,55 cycles.
  - `bit_tick` every 868 cycles; `mid_tick` 434 cycles after each `bit_tick`.
  - `baud_clk` high for 434 and low for 434 cycles.
  - `os_phase` runs 0..15.
- **Integer divisor:** `cfg_load` int=10, frac=0 with `en`=0.
  - `cfg_ack` in the next cycle.
  - After enable: `os_tick` every 10 cycles, `bit_tick` every 160 cycles, first `bit_tick` 160 cycles after `en` rises.
- **Live reprogram:** `cfg_load` int=27, frac=2 mid-bit with `en`=1, then another load int=20, frac=0 before the boundary.
  - Single `cfg_ack` coincident with the next `bit_tick`.
  - Following `os_tick` spacing is exactly 20.
- **Resync:** pulse `resync` at an arbitrary `os_phase`=7.
  - No tick that cycle; `os_phase`=0.
  - `mid_tick` exactly 8 periods later; `bit_tick` 16 periods later.
  - `baud_clk` stays 0 until that `mid_tick`.
- **Invalid config:** `cfg_load` int=1.
  - `cfg_err` pulse, no `cfg_ack`, tick spacing unchanged.
  - A `cfg_load` int=0 behaves identically.
- **Reset/disable mid-bit:**
  - Assert `rst` one cycle at `os_phase`=5 with a pending configuration: outputs go to 0 next cycle, DIV_DEF is restored, no `cfg_ack` follows.
  - `en`=0 for one cycle gives the same clearing of counters and outputs.
